// File: rtl/boot_pkg.sv
// Shared types for the boot sequencer.
// State encoding and byte-lane constants.
package boot_pkg;

  typedef enum logic [2:0] {
    HDR,
    LOAD,
    SETTLE,
    RUN,
    DONE,
    ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/boot_ctrl_byte_packer.sv
// Little-endian byte-to-word assembler.
// Flags the beat that completes a word.
module byte_packer
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        take,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] byte_idx;
  logic [23:0]      acc;
  logic             last;

  assign last       = byte_idx == IDX_W'(BYTES_PER_WORD - 1);
  assign word       = {data, acc};
  assign word_valid = take & last;

  // Shift bytes in from the top so the first lands in [7:0].
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx <= '0;
      acc      <= '0;
    end else if (take) begin
      byte_idx <= byte_idx + IDX_W'(1);
      acc      <= {data, acc[23:8]};
    end
  end

endmodule

// File: rtl/boot_ctrl.sv
// Boot and run sequencer: streams an image into
// instruction memory, then runs the core for a bounded time.
module boot_ctrl
  import boot_pkg::*;
#(
  parameter  int IMEM_DEPTH = 64,
  parameter  int RUN_LIMIT  = 1000,
  localparam int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              err,
  output logic [31:0]       cycle_cnt
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] word_idx;
  logic [ADDR_W-1:0] last_idx;
  logic [31:0]       word;
  logic              word_valid;
  logic              take;
  logic              hdr_bad;
  logic              last_word;
  logic              run_end;

  assign take = ld_valid & ld_ready;

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .take       (take),
    .data       (ld_data),
    .word       (word),
    .word_valid (word_valid)
  );

  assign hdr_bad   = (word == 32'd0) ||
                     (word > 32'(IMEM_DEPTH));
  assign last_word = word_idx == last_idx;
  assign run_end   = (RUN_LIMIT != 0) &&
                     (cycle_cnt == 32'(RUN_LIMIT - 1));

  assign ld_ready   = (state == HDR) || (state == LOAD);
  assign core_reset = state != RUN;
  assign done       = state == DONE;
  assign err        = state == ERR;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= HDR;
    else       state <= state_n;
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    unique case (state)
      HDR: begin
        if (word_valid)
          state_n = hdr_bad ? ERR : LOAD;
      end
      LOAD: begin
        if (word_valid && last_word)
          state_n = SETTLE;
      end
      SETTLE: state_n = RUN;
      RUN: begin
        if (run_end) state_n = DONE;
      end
      DONE:    state_n = DONE;
      ERR:     state_n = ERR;
      default: state_n = HDR;
    endcase
  end

  // Word count latch, write port register and run counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_idx   <= '0;
      last_idx   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cycle_cnt  <= '0;
    end else begin
      imem_we <= 1'b0;
      if (state == HDR && word_valid && !hdr_bad)
        last_idx <= ADDR_W'(word - 32'd1);
      if (state == LOAD && word_valid) begin
        imem_we    <= 1'b1;
        imem_addr  <= word_idx;
        imem_wdata <= word;
        if (!last_word)
          word_idx <= word_idx + ADDR_W'(1);
      end
      if (state == RUN && cycle_cnt != '1)
        cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_boot_ctrl.sv
// Bench for boot_ctrl: write scoreboard plus
// per-scenario directed checks.
module tb_boot_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ld_valid = 1'b0;
  logic [7:0] ld_data = 8'h00;

  logic        ld_ready0, imem_we0, core_reset0;
  logic        done0, err0;
  logic [5:0]  imem_addr0;
  logic [31:0] imem_wdata0, cycle_cnt0;

  logic        ld_ready1, imem_we1, core_reset1;
  logic        done1, err1;
  logic [5:0]  imem_addr1;
  logic [31:0] imem_wdata1, cycle_cnt1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int run0 = 0;
  int run1 = 0;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  wr_t e;

  always #5 clk = ~clk;

  boot_ctrl #(.IMEM_DEPTH(64), .RUN_LIMIT(5)) dut0 (
    .clk        (clk),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready0),
    .imem_we    (imem_we0),
    .imem_addr  (imem_addr0),
    .imem_wdata (imem_wdata0),
    .core_reset (core_reset0),
    .done       (done0),
    .err        (err0),
    .cycle_cnt  (cycle_cnt0)
  );

  boot_ctrl #(.IMEM_DEPTH(64), .RUN_LIMIT(0)) dut1 (
    .clk        (clk),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready1),
    .imem_we    (imem_we1),
    .imem_addr  (imem_addr1),
    .imem_wdata (imem_wdata1),
    .core_reset (core_reset1),
    .done       (done1),
    .err        (err1),
    .cycle_cnt  (cycle_cnt1)
  );

  // Cycle stamp and count of edges seen with the core released.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      run0 <= 0;
      run1 <= 0;
    end else begin
      if (!core_reset0) run0 <= run0 + 1;
      if (!core_reset1) run1 <= run1 + 1;
    end
  end

  // Every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we0 === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_write addr=%0d data=%h",
                 imem_addr0, imem_wdata0);
      end else begin
        e = exp_q.pop_front();
        if (imem_addr0 !== e.addr ||
            imem_wdata0 !== e.data || cyc != e.cyc) begin
          errors++;
          $display({"FAIL imem_write got a=%0d d=%h c=%0d",
                    " exp a=%0d d=%h c=%0d"},
                   imem_addr0, imem_wdata0, cyc,
                   e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    ld_valid = 1'b0;
    ld_data = 8'h00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_data = b;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w,
                           input bit wr,
                           input logic [5:0] a,
                           input bit gap);
    wr_t x;
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8]);
      if (i == 3 && wr) begin
        x.addr = a;
        x.data = w;
        x.cyc = cyc;
        exp_q.push_back(x);
      end
      if (gap) begin
        ld_data = 8'hA5;
        tick();
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({ld_ready0, imem_we0, core_reset0, done0, err0}
        !== 5'b10100) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 10100",
               {ld_ready0, imem_we0, core_reset0, done0, err0});
    end
    checks++;
    if (imem_addr0 !== 6'd0 || imem_wdata0 !== 32'd0 ||
        cycle_cnt0 !== 32'd0) begin
      errors++;
      $display("FAIL reset_data got a=%0d d=%h c=%0d exp 0",
               imem_addr0, imem_wdata0, cycle_cnt0);
    end
  endtask

  task automatic test_load_run();
    apply_reset();
    send_word(32'd2, 1'b0, 6'd0, 1'b0);
    send_word(32'h00100093, 1'b1, 6'd0, 1'b0);
    send_word(32'h00200113, 1'b1, 6'd1, 1'b0);
    @(negedge clk);
    checks++;
    if (core_reset0 !== 1'b1 || ld_ready0 !== 1'b0) begin
      errors++;
      $display("FAIL settle got cr=%b rdy=%b exp cr=1 rdy=0",
               core_reset0, ld_ready0);
    end
    @(negedge clk);
    checks++;
    if (core_reset0 !== 1'b0) begin
      errors++;
      $display("FAIL release got cr=%b exp 0", core_reset0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL load_writes pending=%0d exp 0",
               exp_q.size());
    end
  endtask

  task automatic test_run_limit();
    for (int i = 0; i < 40 && done0 !== 1'b1; i++)
      @(negedge clk);
    checks++;
    if (done0 !== 1'b1 || core_reset0 !== 1'b1 ||
        cycle_cnt0 !== 32'd5 || run0 != 5) begin
      errors++;
      $display({"FAIL run_limit got done=%b cr=%b cnt=%0d",
                " run=%0d exp 1 1 5 5"},
               done0, core_reset0, cycle_cnt0, run0);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (done0 !== 1'b1 || core_reset0 !== 1'b1 ||
          cycle_cnt0 !== 32'd5 || err0 !== 1'b0) begin
        errors++;
        $display("FAIL done_hold got d=%b cr=%b cnt=%0d",
                 done0, core_reset0, cycle_cnt0);
      end
    end
  endtask

  task automatic test_unlimited();
    for (int i = 0; i < 10100 && run1 < 10000; i++)
      @(negedge clk);
    checks++;
    if (run1 != 10000 || cycle_cnt1 !== 32'd10000 ||
        done1 !== 1'b0 || core_reset1 !== 1'b0) begin
      errors++;
      $display({"FAIL unlimited got run=%0d cnt=%0d",
                " done=%b cr=%b exp 10000 10000 0 0"},
               run1, cycle_cnt1, done1, core_reset1);
    end
  endtask

  task automatic bad_header(input logic [31:0] n);
    apply_reset();
    send_word(n, 1'b0, 6'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (err0 !== 1'b1 || ld_ready0 !== 1'b0 ||
        core_reset0 !== 1'b1 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL bad_hdr n=%0d got e=%b r=%b cr=%b d=%b",
               n, err0, ld_ready0, core_reset0, done0);
    end
    for (int i = 0; i < 6; i++) send_byte(8'h13);
    @(negedge clk);
    checks++;
    if (err0 !== 1'b1 || core_reset0 !== 1'b1) begin
      errors++;
      $display("FAIL err_hold n=%0d got e=%b cr=%b exp 1 1",
               n, err0, core_reset0);
    end
  endtask

  task automatic test_bad_header();
    bad_header(32'd0);
    bad_header(32'd65);
    apply_reset();
    send_word(32'd64, 1'b0, 6'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (err0 !== 1'b0 || ld_ready0 !== 1'b1) begin
      errors++;
      $display("FAIL max_hdr got e=%b r=%b exp 0 1",
               err0, ld_ready0);
    end
  endtask

  task automatic test_toggle();
    apply_reset();
    send_word(32'd1, 1'b0, 6'd0, 1'b0);
    send_word(32'hDEADBEEF, 1'b1, 6'd0, 1'b1);
    @(negedge clk);
    checks++;
    if (core_reset0 !== 1'b0 || err0 !== 1'b0 ||
        exp_q.size() != 0) begin
      errors++;
      $display("FAIL toggle got cr=%b e=%b pend=%0d",
               core_reset0, err0, exp_q.size());
    end
  endtask

  task automatic test_reset_midword();
    apply_reset();
    send_word(32'd2, 1'b0, 6'd0, 1'b0);
    send_word(32'h11223344, 1'b1, 6'd0, 1'b0);
    send_byte(8'h55);
    send_byte(8'h66);
    apply_reset();
    send_word(32'd1, 1'b0, 6'd0, 1'b0);
    send_word(32'hCAFEF00D, 1'b1, 6'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (core_reset0 !== 1'b0 || err0 !== 1'b0 ||
        exp_q.size() != 0) begin
      errors++;
      $display("FAIL midword got cr=%b e=%b pend=%0d",
               core_reset0, err0, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_load_run();
    test_run_limit();
    test_unlimited();
    test_bad_header();
    test_toggle();
    test_reset_midword();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue pending=%0d exp 0",
               exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
